// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - multi-cycle 8-bit shift engine with valid/ready on both sides
// Shifts in per-cycle steps of at most STEP_MAX bits until the requested amount is consumed.

module shift_seq8_step #(
   parameter int WIDTH = 8,
   parameter int STW   = 2
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       op,
   input  logic [STW-1:0]   step,
   output logic [WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] dbl;

   always_comb begin
      // rotate-right falls out of shifting a doubled copy of the word
      dbl = {data, data} >> step;
      case (op)
         2'b00:   result = data << step;
         2'b01:   result = data >> step;
         2'b10:   result = $signed(data) >>> step;
         default: result = dbl[WIDTH-1:0];
      endcase
   end

endmodule

module shift_seq8 #(
   parameter int WIDTH    = 8,
   parameter int SHW      = 3,
   parameter int STEP_MAX = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] d_in,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d_out,
   output logic             busy
);

   localparam int STW = $clog2(STEP_MAX + 1);
   localparam logic [SHW-1:0] STEP_MAX_W = SHW'(STEP_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data_r;
   logic [SHW-1:0]   rem_r;
   logic [1:0]       op_r;

   logic [STW-1:0]   step;
   logic [SHW-1:0]   rem_next;
   logic [WIDTH-1:0] data_step;
   logic             accept;

   always_comb begin
      step     = (rem_r > STEP_MAX_W) ? STW'(STEP_MAX) : rem_r[STW-1:0];
      rem_next = rem_r - SHW'(step);
      accept   = in_valid && in_ready;
   end

   shift_seq8_step #(
      .WIDTH (WIDTH),
      .STW   (STW)
   ) u_step (
      .data   (data_r),
      .op     (op_r),
      .step   (step),
      .result (data_step)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         data_r    <= '0;
         rem_r     <= '0;
         op_r      <= '0;
         d_out     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  data_r   <= d_in;
                  op_r     <= op;
                  rem_r    <= shamt;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
                  if (shamt == '0) begin
                     state     <= DONE;
                     d_out     <= d_in;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SHIFT: begin
               data_r <= data_step;
               rem_r  <= rem_next;
               if (rem_next == '0) begin
                  state     <= DONE;
                  d_out     <= data_step;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // d_out keeps the result after the handshake until the next DONE entry
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule
